// File: rtl/diff_serial_rx_if.sv
// diff_serial_rx_if: bundles the line-side sample strobe and the word-side
// valid/ready buffer of the differential serial receiver, plus its status
// pulses.
//
// Parameter:
//   WIDTH      data bits per word (2..32)
// Signals:
//   in_valid   line sample strobe              (sampler -> receiver)
//   in_bit     encoded line bit                (sampler -> receiver)
//   out_data   received word                   (receiver -> consumer)
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data       (consumer -> receiver)
//   busy       a frame is being received
//   frame_err  one-cycle pulse, bad stop bit
//   parity_err one-cycle pulse, parity failure
//   overrun    one-cycle pulse, completed word dropped
// Modports:
//   master     receiver side (drives the word and status outputs)
//   slave      sampler/consumer side
interface diff_serial_rx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_bit;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             frame_err;
   logic             parity_err;
   logic             overrun;

   modport master (
      input  in_valid, in_bit, out_ready,
      output out_data, out_valid, busy, frame_err, parity_err, overrun
   );

   modport slave (
      output in_valid, in_bit, out_ready,
      input  out_data, out_valid, busy, frame_err, parity_err, overrun
   );
endinterface

// File: rtl/diff_serial_rx.sv
// diff_serial_rx: differential-decoding serial receiver.
// Each sampled line bit is XORed with the previous sampled line bit to give
// the data bit d. The decoded stream is framed as start(0), WIDTH data bits
// LSB first, optional even-parity bit, stop(1). Good words are presented on a
// one-entry valid/ready buffer.
//
// Optional feature macro: DIFF_RX_PARITY_EN
//   defined   : parity bit present (frame WIDTH+3 bits), parity_err active
//   undefined : no parity bit (frame WIDTH+2 bits), parity_err tied to 0
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   diff_serial_rx_if.master (in_valid, in_bit, out_ready in;
//         out_data, out_valid, busy, frame_err, parity_err, overrun out)
module diff_serial_rx #(
   parameter int unsigned WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   diff_serial_rx_if.master  bus
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t           state;
   logic             prev;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             fe_q;
   logic             ov_q;
   logic             d;
   logic             last_bit;
   logic             parity_ok;
   logic             accept;

`ifdef DIFF_RX_PARITY_EN
   logic             par_q;
   logic             pe_q;
`endif

   assign d        = bus.in_bit ^ prev;
   assign last_bit = (count == CW'(WIDTH - 1));
   assign accept   = valid_q & bus.out_ready;

`ifdef DIFF_RX_PARITY_EN
   // Even parity: data bits plus parity bit must XOR to zero.
   assign parity_ok = ((^shreg) == par_q);
`else
   assign parity_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         prev    <= 1'b0;
         count   <= '0;
         shreg   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
`ifdef DIFF_RX_PARITY_EN
         par_q   <= 1'b0;
         pe_q    <= 1'b0;
`endif
      end else begin
         fe_q <= 1'b0;
         ov_q <= 1'b0;
`ifdef DIFF_RX_PARITY_EN
         pe_q <= 1'b0;
`endif
         // Consumption clears the buffer; a word completing on the same edge
         // overrides this below.
         if (accept) begin
            valid_q <= 1'b0;
         end

         if (bus.in_valid) begin
            prev <= bus.in_bit;
            unique case (state)
               IDLE: begin
                  if (!d) begin
                     state <= DATA;
                     count <= '0;
                  end
               end
               DATA: begin
                  shreg[count] <= d;
                  count        <= count + 1'b1;
                  if (last_bit) begin
`ifdef DIFF_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
               PARITY: begin
`ifdef DIFF_RX_PARITY_EN
                  par_q <= d;
`endif
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  // A bad stop bit masks any parity failure.
                  if (!d) begin
                     fe_q <= 1'b1;
                  end else if (!parity_ok) begin
`ifdef DIFF_RX_PARITY_EN
                     pe_q <= 1'b1;
`endif
                  end else if (!valid_q || accept) begin
                     data_q  <= shreg;
                     valid_q <= 1'b1;
                  end else begin
                     ov_q <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.busy      = (state != IDLE);
   assign bus.frame_err = fe_q;
   assign bus.overrun   = ov_q;
`ifdef DIFF_RX_PARITY_EN
   assign bus.parity_err = pe_q;
`else
   assign bus.parity_err = 1'b0;
`endif

endmodule

// File: doc/diff_serial_rx.md
# diff_serial_rx

Differential-decoding serial receiver: recovers each data bit as the XOR of the current and previous line bits, frames the decoded stream, deserializes it into WIDTH-bit words and presents them on a one-entry valid/ready output buffer. It is the receiving end of the team's XOR-based differential serial link and sits between the line sampler and any word-level consumer.

## Interface
- WIDTH, default 8: data bits per frame, from 2 to 32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_bit is sampled on this cycle.
- in_bit  input  1  encoded line bit.
- out_data  output  WIDTH  received word; reset 0.
- out_valid  output  1  out_data holds an unconsumed word; reset 0.
- out_ready  input  1  consumer accepts out_data when out_valid is high.
- busy  output  1  a frame is in progress (state other than IDLE); reset 0.
- frame_err  output  1  one-cycle pulse when a bad stop bit is received; reset 0.
- parity_err  output  1  one-cycle pulse when parity fails; reset 0.
- overrun  output  1  one-cycle pulse when a completed word is dropped; reset 0.

## Operation
- Decode: on each in_valid cycle, d = in_bit ^ prev, then prev <= in_bit. prev resets to 0. Nothing changes on cycles where in_valid is low, except the output handshake.
- Frame, in decoded bits: start (0), WIDTH data bits LSB first, parity bit (even parity over the data, only with the macro), stop (1).
- State machine:
  - IDLE: d=0 -> DATA with bit count 0; d=1 -> stay in IDLE.
  - DATA: shift d into bit position count. When count = WIDTH-1, go to PARITY if the macro is defined, else to STOP.
  - PARITY: store d -> STOP.
  - STOP: d=1 and parity OK -> complete the word; d=0 -> frame_err. Either way, return to IDLE.
- Error priority: if d=0 in STOP, only frame_err pulses, even when parity also fails. A parity failure alone pulses parity_err.
- Errored words are discarded; out_data and out_valid are unchanged.
- Completion:
  - If the buffer is empty, or is being accepted this cycle (out_valid & out_ready), load out_data and hold out_valid=1.
  - Otherwise pulse overrun, drop the new word, and keep the old word.
- Handshake: a transfer happens on any cycle with out_valid & out_ready. out_valid falls the next cycle unless a word completes on that same cycle. out_data stays stable while out_valid is high.
- rst mid-frame: return to IDLE immediately, clear prev, the shift register and all outputs, and drop the partial word.

## Timing
- Latency: out_valid rises on the clock edge that samples the stop bit, i.e. it is visible in the following cycle.
- Error pulses are registered on the same edge and last exactly one cycle.
- Back-to-back frames need no idle bits: a start bit may be sampled on the in_valid cycle immediately after the stop bit.
- in_valid may be low for any number of cycles between bits; frame state is held throughout.
- Throughput: one word per WIDTH+3 in_valid samples (WIDTH+2 without the macro).

## Configuration
- DIFF_RX_PARITY_EN defined:
  - The PARITY state exists and the frame is WIDTH+3 bits.
  - parity_err is active.
- DIFF_RX_PARITY_EN undefined:
  - No PARITY state; STOP follows the last data bit and the frame is WIDTH+2 bits.
  - parity_err is tied to 0.

## Test plan
In every test the bench encodes with line = d ^ prev_line, starting from prev_line = 0 after reset, and runs with the macro defined unless stated.
- Send 0xA5 (parity 0) with out_ready=1 -> out_data=0xA5, out_valid high for 1 cycle, no error pulses.
- Send 0x3C then 0x81 back-to-back with out_ready=0, then raise out_ready -> 0x3C delivered, overrun pulses once, and 0x81 is never presented.
- Send 0x01 with the parity bit forced to 0 -> parity_err pulses once, out_valid stays 0, and a following good 0x02 is received correctly.
- Send 0xFF with the stop bit forced to 0 and the parity bit also wrong -> frame_err only, no parity_err, then IDLE.
- Assert rst after 4 data bits of 0x55, then send 0x66 -> out_data=0x66 with no errors.
- Without the macro, send 0xC3 with a 10-bit frame and in_valid toggling every other cycle -> out_data=0xC3 and parity_err stays 0.
